apb_xfer_engine: RTL
====================

// Module: apb_xfer_engine
// PURPOSE
//  APB master stage downstream of the AXI-side bridgebuffer. Takes one burst command at a time
//  (type, id, addr, len, size) and issues len+1 single APB transfers at incrementing addresses.
//  Write beats come from the write-data FIFO. Read data returns per beat, and one write
//  response returns per burst, back to the AXI side.
// PARAMETERS
//  ID_WIDTH    1   AXI transaction ID width
//  ADDR_WIDTH  32  APB/AXI address width
//  DATA_WIDTH  32  APB data width (bytes/beat = DATA_WIDTH/8)
// PORTS
//  clk           in   1           single clock, all logic rising-edge
//  rst_n         in   1           asynchronous active-low reset
//  cmd_valid_i   in   1           burst command valid
//  cmd_ready_o   out  1           engine idle, command accepted when valid&ready
//  cmd_write_i   in   1           0=READ, 1=WRITE
//  cmd_id_i      in   ID_WIDTH    transaction ID
//  cmd_addr_i    in   ADDR_WIDTH  first-beat address
//  cmd_len_i     in   8           beats-1
//  cmd_size_i    in   3           log2 bytes per beat
//  wdata_valid_i in   1           write beat available
//  wdata_ready_o out  1           write beat consumed when valid&ready
//  wdata_i       in   DATA_WIDTH  write beat data
//  rdata_valid_o out  1           read beat valid
//  rdata_ready_i in   1           read beat taken
//  rdata_o       out  DATA_WIDTH  read beat data
//  rdata_id_o    out  ID_WIDTH    read beat ID
//  rdata_resp_o  out  2           00 OKAY, 10 SLVERR
//  rdata_last_o  out  1           final beat of burst
//  bresp_valid_o out  1           write response valid
//  bresp_ready_i in   1           write response taken
//  bresp_id_o    out  ID_WIDTH    write response ID
//  bresp_o       out  2           00 OKAY, 10 SLVERR
//  psel_o        out  1           APB select
//  penable_o     out  1           APB enable
//  pwrite_o      out  1           APB direction
//  paddr_o       out  ADDR_WIDTH  APB address
//  pwdata_o      out  DATA_WIDTH  APB write data
//  pready_i      in   1           APB ready
//  prdata_i      in   DATA_WIDTH  APB read data
//  pslverr_i     in   1           APB slave error
// BEHAVIOUR
//  Reset values: all registered outputs are 0 (psel, penable, pwrite, paddr, pwdata, rdata_*, bresp_*).
//    cmd_ready_o = (state==IDLE), so it reads 1 out of reset. wdata_ready_o = (state==WAIT_WD).
//  States: IDLE, WAIT_WD, SETUP, ACCESS, RD_OUT, WR_RESP.
//  IDLE: on cmd_valid_i, latch id/addr/size/type and set beats_left = cmd_len_i.
//    Next state is WAIT_WD for a write, SETUP for a read.
//  WAIT_WD: on wdata_valid_i, capture wdata_i into pwdata_o and go to SETUP.
//  SETUP: exactly 1 cycle with psel=1, penable=0; paddr/pwrite stable. Then go to ACCESS.
//  ACCESS: psel=1, penable=1 until pready_i. paddr, pwrite and pwdata are held throughout.
//    On pready_i, psel and penable drop the next cycle.
//    Read: register prdata_i, set resp = pslverr_i ? 10 : 00, last = (beats_left==0). Go to RD_OUT.
//    Write: err_acc |= pslverr_i.
//      If beats_left==0, go to WR_RESP.
//      Otherwise go to WAIT_WD with beats_left-1 and addr+=incr.
//  RD_OUT: rdata_valid_o is held with stable payload until rdata_ready_i.
//    On the handshake: if last, go to IDLE; otherwise go to SETUP with beats_left-1 and addr+=incr.
//  WR_RESP: bresp_valid_o=1, bresp_o = err_acc ? 10 : 00, held until bresp_ready_i.
//    Then clear err_acc and go to IDLE.
//  Address increment:
//    incr = 1 << min(size, $clog2(DATA_WIDTH/8)); oversize requests are clamped.
//    The add is ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH. No 4KB check (upstream guarantees it).
//  Latency: read beat is visible 1 cycle after the pready cycle. Minimum per read beat is 3 cycles
//    (SETUP, ACCESS, RD_OUT) with pready=1 and rdata_ready=1. Write beat minimum is 3 cycles
//    (WAIT_WD, SETUP, ACCESS).
//  pslverr does not abort a burst; all len+1 beats are always issued.
//  One burst in flight only. cmd_ready_o=0 outside IDLE, so back-to-back commands cost one IDLE cycle.
//  Reset mid-burst: APB and valid outputs drop to 0 asynchronously, the burst is abandoned,
//    and no partial response is emitted.
// TESTING
//  1. Read len=0, addr=0x1000, size=2, pready=1, prdata=0xDEADBEEF.
//     -> one SETUP then ACCESS at 0x1000; rdata=0xDEADBEEF, resp=00, last=1.
//  2. Read len=3, addr=0x0FFC, size=2, pready delayed by 2 wait cycles per beat.
//     -> paddr 0x0FFC, 0x1000, 0x1004, 0x1008; penable held during waits; last only on beat 4.
//  3. Write len=2, beat 1 with pslverr=1.
//     -> 3 APB writes with data in FIFO order; a single bresp=10 after the third pready.
//  4. Backpressure: rdata_ready=0 for 5 cycles on beat 1.
//     -> rdata payload stable; no new SETUP until the handshake.
//  5. addr=0xFFFFFFFC, len=1, size=2.
//     -> second paddr = 0x00000000 (wrap). size=5 with DATA_WIDTH=32 -> incr clamped to 4.
//  6. rst_n low in ACCESS of a 4-beat write.
//     -> psel, penable and bresp_valid go 0 immediately; after release cmd_ready_o=1 and a new
//        command completes normally.

Source files
------------

// File: rtl/apb_xfer_engine_if.sv
// Bundle of the command, write-data, read-data, write-response and APB
// signals around apb_xfer_engine. The engine connects to the slave modport.
// The master modport is the view from the surrounding logic: the AXI-side
// buffer and the APB completer.
interface apb_xfer_engine_if #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_write_i;
  logic [ID_WIDTH-1:0]   cmd_id_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [7:0]            cmd_len_i;
  logic [2:0]            cmd_size_i;
  logic                  wdata_valid_i;
  logic                  wdata_ready_o;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  rdata_valid_o;
  logic                  rdata_ready_i;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic [ID_WIDTH-1:0]   rdata_id_o;
  logic [1:0]            rdata_resp_o;
  logic                  rdata_last_o;
  logic                  bresp_valid_o;
  logic                  bresp_ready_i;
  logic [ID_WIDTH-1:0]   bresp_id_o;
  logic [1:0]            bresp_o;
  logic                  psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [ADDR_WIDTH-1:0] paddr_o;
  logic [DATA_WIDTH-1:0] pwdata_o;
  logic                  pready_i;
  logic [DATA_WIDTH-1:0] prdata_i;
  logic                  pslverr_i;

  modport slave (
    input  cmd_valid_i, cmd_write_i, cmd_id_i, cmd_addr_i, cmd_len_i, cmd_size_i,
    input  wdata_valid_i, wdata_i, rdata_ready_i, bresp_ready_i,
    input  pready_i, prdata_i, pslverr_i,
    output cmd_ready_o, wdata_ready_o,
    output rdata_valid_o, rdata_o, rdata_id_o, rdata_resp_o, rdata_last_o,
    output bresp_valid_o, bresp_id_o, bresp_o,
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );

  modport master (
    output cmd_valid_i, cmd_write_i, cmd_id_i, cmd_addr_i, cmd_len_i, cmd_size_i,
    output wdata_valid_i, wdata_i, rdata_ready_i, bresp_ready_i,
    output pready_i, prdata_i, pslverr_i,
    input  cmd_ready_o, wdata_ready_o,
    input  rdata_valid_o, rdata_o, rdata_id_o, rdata_resp_o, rdata_last_o,
    input  bresp_valid_o, bresp_id_o, bresp_o,
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );
endinterface

// File: rtl/apb_xfer_engine.sv
// APB master stage. Accepts one burst command at a time and issues len+1
// single APB transfers at incrementing addresses. Read beats return one by
// one. A write burst returns one response carrying the accumulated error.
module apb_xfer_engine #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  apb_xfer_engine_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, WAIT_WD, SETUP, ACCESS, RD_OUT, WR_RESP
  } state_t;

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH/8));

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            size_q, size_d;
  logic                  write_q, write_d;
  logic [7:0]            beats_q, beats_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d;
  logic                  err_q, err_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  rvalid_q, rvalid_d;
  logic                  bvalid_q, bvalid_d;

  logic [2:0]            size_eff;
  logic [ADDR_WIDTH-1:0] incr;

  // Beat stride: requested size clamped to the bus width.
  always_comb begin
    size_eff = (size_q > MAX_SIZE) ? MAX_SIZE : size_q;
    incr     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << size_eff;
  end

  // Next-state and datapath updates for the burst sequencer.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    size_d   = size_q;
    write_d  = write_q;
    beats_d  = beats_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          id_d    = bus.cmd_id_i;
          addr_d  = bus.cmd_addr_i;
          size_d  = bus.cmd_size_i;
          write_d = bus.cmd_write_i;
          beats_d = bus.cmd_len_i;
          err_d   = 1'b0;
          state_d = bus.cmd_write_i ? WAIT_WD : SETUP;
        end
      end
      WAIT_WD: begin
        if (bus.wdata_valid_i) begin
          pwdata_d = bus.wdata_i;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (bus.pready_i) begin
          if (!write_q) begin
            rdata_d = bus.prdata_i;
            rresp_d = bus.pslverr_i ? 2'b10 : 2'b00;
            rlast_d = (beats_q == 8'd0);
            state_d = RD_OUT;
          end else begin
            err_d = err_q | bus.pslverr_i;
            if (beats_q == 8'd0) begin
              state_d = WR_RESP;
            end else begin
              beats_d = beats_q - 8'd1;
              addr_d  = addr_q + incr;
              state_d = WAIT_WD;
            end
          end
        end
      end
      RD_OUT: begin
        if (bus.rdata_ready_i) begin
          if (rlast_q) begin
            state_d = IDLE;
          end else begin
            beats_d = beats_q - 8'd1;
            addr_d  = addr_q + incr;
            state_d = SETUP;
          end
        end
      end
      WR_RESP: begin
        if (bus.bresp_ready_i) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Strobes are registered from the next state so they change cleanly on the edge.
    psel_d    = (state_d == SETUP) || (state_d == ACCESS);
    penable_d = (state_d == ACCESS);
    rvalid_d  = (state_d == RD_OUT);
    bvalid_d  = (state_d == WR_RESP);
  end

  // State and output registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      write_q   <= 1'b0;
      beats_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
      err_q     <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rvalid_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      write_q   <= write_d;
      beats_q   <= beats_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      err_q     <= err_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rvalid_q  <= rvalid_d;
      bvalid_q  <= bvalid_d;
    end
  end

  assign bus.cmd_ready_o   = (state_q == IDLE);
  assign bus.wdata_ready_o = (state_q == WAIT_WD);
  assign bus.rdata_valid_o = rvalid_q;
  assign bus.rdata_o       = rdata_q;
  assign bus.rdata_id_o    = id_q;
  assign bus.rdata_resp_o  = rresp_q;
  assign bus.rdata_last_o  = rlast_q;
  assign bus.bresp_valid_o = bvalid_q;
  assign bus.bresp_id_o    = id_q;
  assign bus.bresp_o       = {err_q, 1'b0};
  assign bus.psel_o        = psel_q;
  assign bus.penable_o     = penable_q;
  assign bus.pwrite_o      = write_q;
  assign bus.paddr_o       = addr_q;
  assign bus.pwdata_o      = pwdata_q;

endmodule
